// File: rtl/cla_seq_adder_ctrl_if.sv
// Request/result bundle between a requester and the sequential CLA adder controller.
// The requester drives the operands and start; the controller returns busy/done and the registered result.
interface cla_seq_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/cla_seq_adder_ctrl.sv
// WIDTH-bit adder that runs one 4-bit carry-lookahead slice once per nibble, LSB first.
// A result costs NIB+1 cycles back to back; sum/cout only move on the completion edge.
module Carry_look_ahead_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       Cout
);
  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // Every carry is a flat function of g/p/cin, so no carry ripples between bits.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sum
      assign sum[gi] = p[gi] ^ c[gi];
    end
  endgenerate

  assign Cout = c[4];
endmodule

module cla_seq_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  cla_seq_adder_ctrl_if.slave bus
);
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_reg;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic              carry_reg;
  logic [IDXW-1:0]   idx_reg;
  logic [WIDTH-1:0]  acc_reg;
  logic [WIDTH-1:0]  sum_reg;
  logic              cout_reg;
  logic              busy_reg;
  logic              done_reg;

  logic [3:0]        a_nib [NIB];
  logic [3:0]        b_nib [NIB];
  logic [3:0]        slice_a;
  logic [3:0]        slice_b;
  logic [3:0]        slice_sum;
  logic              slice_cout;
  logic [WIDTH-1:0]  acc_merged;
  logic              accept;
  logic              last_step;

  genvar gi;
  generate
    for (gi = 0; gi < NIB; gi++) begin : g_nib
      assign a_nib[gi] = a_reg[4*gi +: 4];
      assign b_nib[gi] = b_reg[4*gi +: 4];
      // The current nibble goes straight into the merged view so the final step can publish it.
      assign acc_merged[4*gi +: 4] = (idx_reg == IDXW'(gi)) ? slice_sum : acc_reg[4*gi +: 4];
    end
  endgenerate

  assign slice_a = a_nib[idx_reg];
  assign slice_b = b_nib[idx_reg];

  Carry_look_ahead_adder u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .Cout (slice_cout)
  );

  assign accept    = bus.start && ((state_reg == IDLE) || (state_reg == DONE));
  assign last_step = (idx_reg == IDXW'(NIB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      acc_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (accept) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            carry_reg <= bus.cin;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          acc_reg   <= acc_merged;
          carry_reg <= slice_cout;
          idx_reg   <= idx_reg + IDXW'(1);
          if (last_step) begin
            sum_reg   <= acc_merged;
            cout_reg  <= slice_cout;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= DONE;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;
endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Bench for cla_seq_adder_ctrl at WIDTH=16: directed vector table, handshake corner cases,
// and a randomized sweep scored against plain a+b+cin arithmetic.
module tb_cla_seq_adder_ctrl;
  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   vec_count;
  int   miss_count;
  int   done_cnt;
  int   accept_cnt;

  cla_seq_adder_ctrl_if #(.WIDTH(W)) bus ();

  cla_seq_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && bus.done) done_cnt++;
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one operation starting just after a rising edge; returns once done is seen or the bound runs out.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       output int lat, output int busy_cyc);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.cin   = 1'($urandom);
    accept_cnt++;
    lat      = 0;
    busy_cyc = bus.busy ? 1 : 0;
    while (!bus.done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy) busy_cyc++;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int lat;
    int busy_cyc;
    int dc;
    logic [W:0] ref_res;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rc;

    vec_count  = 0;
    miss_count = 0;
    done_cnt   = 0;
    accept_cnt = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    bus.cin    = 1'b0;

    vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
    vecs[3] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0};
    vecs[4] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[6] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(1);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_done", 32'(bus.done), 0);
    check("reset_sum",  32'(bus.sum),  0);
    check("reset_cout", 32'(bus.cout), 0);

    // Vectors 3 and 4 are issued in the DONE cycle of the previous op, i.e. back to back.
    for (int i = 0; i < 8; i++) begin
      if (i == 2 || i == 6) idle_cycles(2);
      if (i == 4) check("b2b_done_still_high", 32'(bus.done), 1);
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat, busy_cyc);
      $display("vec %0d: %h + %h + %0d -> sum %h cout %0d lat %0d", i, vecs[i].a, vecs[i].b,
               vecs[i].cin, bus.sum, bus.cout, lat);
      check($sformatf("vec%0d_sum", i), 32'(bus.sum), 32'(vecs[i].exp_sum));
      check($sformatf("vec%0d_cout", i), 32'(bus.cout), 32'(vecs[i].exp_cout));
      check($sformatf("vec%0d_latency", i), 32'(lat), 4);
      check($sformatf("vec%0d_busy_cycles", i), 32'(busy_cyc), 4);
    end

    // Start pulsed with new operands while busy must be ignored.
    idle_cycles(2);
    dc = done_cnt;
    bus.start = 1'b1;
    bus.a     = 16'h000F;
    bus.b     = 16'h0001;
    bus.cin   = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    accept_cnt++;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a     = 16'hFFFF;
    bus.b     = 16'hFFFF;
    bus.cin   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 2;
    while (!bus.done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    $display("ignore-start op: sum %h cout %0d lat %0d", bus.sum, bus.cout, lat);
    check("ignore_latency", 32'(lat), 4);
    check("ignore_sum", 32'(bus.sum), 32'h0010);
    check("ignore_cout", 32'(bus.cout), 0);
    idle_cycles(4);
    check("ignore_one_done", 32'(done_cnt - dc), 1);
    check("ignore_done_low", 32'(bus.done), 0);

    // Asynchronous reset two cycles into an operation.
    bus.start = 1'b1;
    bus.a     = 16'h1111;
    bus.b     = 16'h2222;
    bus.cin   = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    $display("mid-op reset: busy %0d done %0d sum %h cout %0d", bus.busy, bus.done, bus.sum, bus.cout);
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_done", 32'(bus.done), 0);
    check("midrst_sum",  32'(bus.sum),  0);
    check("midrst_cout", 32'(bus.cout), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dc = done_cnt;
    idle_cycles(8);
    check("midrst_no_done", 32'(done_cnt - dc), 0);
    check("midrst_idle_busy", 32'(bus.busy), 0);
    do_op(16'h8000, 16'h8000, 1'b0, lat, busy_cyc);
    $display("post-reset op: sum %h cout %0d lat %0d", bus.sum, bus.cout, lat);
    check("postrst_sum", 32'(bus.sum), 32'h0000);
    check("postrst_cout", 32'(bus.cout), 1);
    check("postrst_latency", 32'(lat), 4);

    // Random sweep; a zero gap lands the next start in the DONE cycle.
    idle_cycles(2);
    dc = done_cnt;
    accept_cnt = 0;
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      ref_res = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
      do_op(ra, rb, rc, lat, busy_cyc);
      $display("rnd %0d: %h + %h + %0d -> %0d:%h (ref %0d:%h)", n, ra, rb, rc, bus.cout, bus.sum,
               ref_res[W], ref_res[W-1:0]);
      check("rnd_sum", 32'(bus.sum), 32'(ref_res[W-1:0]));
      check("rnd_cout", 32'(bus.cout), 32'(ref_res[W]));
      check("rnd_latency", 32'(lat), 4);
      idle_cycles($urandom_range(0, 3));
    end
    idle_cycles(3);
    check("rnd_done_count", 32'(done_cnt - dc), 32'(accept_cnt));

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end
endmodule

// File: doc/cla_seq_adder_ctrl.md
Name: cla_seq_adder_ctrl

Overview:
- Sequencer that adds two WIDTH-bit operands by time-multiplexing one instance of the team's existing 4-bit Carry_look_ahead_adder slice (ports a, b, cin, sum, Cout).
- Each cycle it feeds one nibble pair and the registered carry into the slice, from LSB nibble to MSB nibble.
- Sits between a requester (start/done handshake) and the shared CLA slice, trading latency for area on wide adds.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 4.
- NIB (derived localparam), WIDTH/4, number of nibble steps per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse/level; sampled only when the controller can accept
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse: result valid
- sum  output  WIDTH  registered result of last completed operation
- cout  output  1  registered carry-out of last completed operation

Behaviour:
- Reset (rst_n=0, async): state=IDLE, busy=0, done=0, sum=0, cout=0, nibble index=0, carry reg=0, operand regs=0. Applies immediately, including mid-operation; the in-flight operation is discarded and the requester must re-issue start.
- FSM states are IDLE, RUN and DONE.
- IDLE: if start=1 at edge k:
  - latch a, b, cin (carry reg<=cin);
  - index<=0, busy<=1, go RUN.
- RUN, each edge:
  - slice inputs = a_reg[4*idx+:4], b_reg[4*idx+:4], carry reg;
  - slice sum nibble is written into the internal accumulator at [4*idx+:4];
  - carry reg<=Cout, idx<=idx+1.
- Last RUN step (idx==NIB-1), same edge:
  - sum<=full accumulator including this nibble; cout<=slice Cout;
  - done<=1, busy<=0, go DONE.
- DONE (one cycle): done=1. Next edge sets done<=0.
  - If start=1 at that edge, accept a new operation exactly as in IDLE: busy<=1, go RUN. This gives back-to-back throughput of one operation per NIB+1 cycles.
  - Otherwise go IDLE.
- Latency: with start accepted at edge k, done is high in the cycle after edge k+NIB (NIB=4 → edge k+4). busy is high from edge k+1 through edge k+NIB.
- start while busy=1 is ignored; operands are not re-latched.
- sum/cout change only at the completion edge and hold until the next completion or reset. Intermediate nibbles are never visible on sum.
- Index counter width is clog2(NIB) with a minimum of 1 bit. When WIDTH=4 (NIB=1), RUN lasts exactly one cycle.
- Arithmetic: {cout,sum} = a + b + cin modulo 2^(WIDTH+1). No overflow flag.
- Operand inputs may change freely after the accepting edge without affecting the result.

Test Plan (WIDTH=16):
- Reset, then start with a=0x0000, b=0x0000, cin=0 → done pulses 4 edges after accept; sum=0x0000, cout=0; busy high exactly 4 cycles.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1 (carry propagates through all nibbles). Then a=0x1234, b=0x4321, cin=1 → sum=0x5556, cout=0.
- a=0xA5A5, b=0x5A5A: with cin=0 → sum=0xFFFF, cout=0; issued back-to-back in the DONE cycle with cin=1 → sum=0x0000, cout=1, done after another 4 edges.
- Start accepted with a=0x000F, b=0x0001; change a/b and pulse start during busy → ignored; result sum=0x0010, cout=0; exactly one done pulse.
- Assert rst_n=0 two cycles into an operation → busy/done/sum/cout go 0 immediately; after release there is no done until a new start. Next start with 0x8000+0x8000, cin=0 → sum=0x0000, cout=1.
- Random sweep of 1000 operations with random inter-start gaps → every result matches the a+b+cin reference model, and the done count equals the accepted-start count.
